// File: rtl/ps2_kbd_rx_fifo_if.sv
// Consumer-side bus of the PS/2 keyboard receiver: key-event FIFO head,
// pop handshake, occupancy and sticky status flags.
interface ps2_kbd_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic          nextdata_n;
    logic          clr_flags;
    logic [9:0]    data;
    logic          ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    err_cnt;

    modport master (
        output nextdata_n, clr_flags,
        input  data, ready, level, overflow, err_cnt
    );

    modport slave (
        input  nextdata_n, clr_flags,
        output data, ready, level, overflow, err_cnt
    );
endinterface

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and deglitch the pins, deserialise
// 11-bit frames, fold E0/F0 prefixes into key events and queue them.
module ps2_kbd_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int OVF_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    ps2_kbd_rx_fifo_if.slave        bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // f[0] start, f[8:1] D0..D7, f[9] parity, f[10] stop
    function automatic logic frame_ok(input logic [10:0] f);
        return !f[0] && f[10] && (^f[9:1]);
    endfunction

    logic [1:0]    clk_s_q, clk_s_d;
    logic [1:0]    dat_s_q, dat_s_d;
    logic          filt_q, filt_d;
    logic          filt_prev_q, filt_prev_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic          strobe;
    logic          frame_done;
    logic          frame_good;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          ovf_evt;
    logic          err_evt;
    logic [7:0]    byte_v;
    logic [9:0]    wr_data;

    // Input conditioning: 2-flop synchronisers, then a run-length filter on ps2_clk
    always_comb begin
        clk_s_d     = {clk_s_q[0], ps2_clk};
        dat_s_d     = {dat_s_q[0], ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        filt_prev_d = filt_q;
        if (clk_s_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s_q[1];
            else                                   filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end

    assign strobe = filt_prev_q & ~filt_q;

    // Frame receiver; the timeout only runs while a frame is partially received
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        frame_done = 1'b0;
        frame_good = 1'b0;
        if (strobe) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd10) begin
                frame_done = 1'b1;
                frame_good = frame_ok({dat_s_q[1], shift_q});
                bit_cnt_d  = '0;
            end else begin
                shift_d[bit_cnt_q] = dat_s_q[1];
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d = '0;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign byte_v  = shift_q[8:1];
    assign wr_data = {ext_q, brk_q, byte_v};

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        push    = 1'b0;
        err_evt = 1'b0;
        if (frame_done) begin
            if (!frame_good) begin
                err_evt = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end else if (byte_v == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_v == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // FIFO: a simultaneous pop always frees the slot a full-FIFO push needs
    assign full = (level_q == LW'(FIFO_DEPTH));
    assign pop  = (level_q != '0) && !bus.nextdata_n;

    always_comb begin
        wr_en    = 1'b0;
        ovf_evt  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push) begin
            if (!full || pop) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (!pop) level_d = level_q + LW'(1);
            end else if (OVF_MODE == 1) begin
                wr_en    = 1'b1;
                ovf_evt  = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                ovf_evt = 1'b1;
            end
        end else if (pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        overflow_d = bus.clr_flags ? 1'b0 : overflow_q;
        err_cnt_d  = bus.clr_flags ? 8'd0 : err_cnt_q;
        if (ovf_evt) overflow_d = 1'b1;
        if (err_evt) err_cnt_d  = sat_inc8(err_cnt_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s_q     <= 2'b11;
            dat_s_q     <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            clk_s_q     <= clk_s_d;
            dat_s_q     <= dat_s_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign bus.data     = mem_q[rd_ptr_q];
    assign bus.ready    = (level_q != '0);
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed bench: two 4-deep receivers (drop / overwrite policy) share the
// PS/2 pins; frames are bit-banged and outputs checked with assertions.
module tb_ps2_kbd_rx_fifo;
    localparam int DEPTH = 4;
    localparam int FILT  = 4;
    localparam int TMO   = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic nextdata_n = 1'b1;
    logic clr_flags = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ps2_kbd_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) if0 ();
    ps2_kbd_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) if1 ();

    assign if0.nextdata_n = nextdata_n;
    assign if0.clr_flags  = clr_flags;
    assign if1.nextdata_n = nextdata_n;
    assign if1.clr_flags  = clr_flags;

    ps2_kbd_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FILT), .TIMEOUT_CYC(TMO), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(if0)
    );
    ps2_kbd_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FILT), .TIMEOUT_CYC(TMO), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(if1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                               input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Sends bits f[0..nb-1]; after bit glitch_at a short low pulse is put on ps2_clk
    task automatic send_bits(input logic [10:0] f, input int nb, input int glitch_at);
        for (int i = 0; i < nb; i++) begin
            ps2_data = f[i];
            tick(10);
            ps2_clk = 1'b0;
            tick(20);
            ps2_clk = 1'b1;
            tick(10);
            if (i == glitch_at) begin
                ps2_clk = 1'b0;
                tick(FILT - 1);
                ps2_clk = 1'b1;
                tick(10);
            end
        end
        ps2_data = 1'b1;
        tick(20);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0, 1'b0), 11, -1);
    endtask

    task automatic pop1();
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
        tick(1);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_ready",    32'(if0.ready),    32'h0);
        check("rst_level",    32'(if0.level),    32'h0);
        check("rst_overflow", 32'(if0.overflow), 32'h0);
        check("rst_err_cnt",  32'(if0.err_cnt),  32'h0);

        // Single valid key 0x1C
        send_byte(8'h1C);
        check("k1c_ready", 32'(if0.ready), 32'h1);
        check("k1c_data",  32'(if0.data),  32'h01C);
        check("k1c_level", 32'(if0.level), 32'h1);
        pop1();
        check("k1c_pop_ready", 32'(if0.ready), 32'h0);

        // Pop request while empty must not disturb anything
        pop1();
        check("empty_pop_level", 32'(if0.level), 32'h0);

        // Extended break sequence folds into one entry
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("e0f075_level", 32'(if0.level), 32'h1);
        check("e0f075_data",  32'(if0.data),  32'h375);
        send_byte(8'h1C);
        check("flags_clr_level", 32'(if0.level), 32'h2);
        pop1();
        check("flags_clr_data",  32'(if0.data),  32'h01C);
        pop1();
        check("seq_drained", 32'(if0.level), 32'h0);

        // Framing errors
        send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11, -1);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, -1);
        check("err_cnt2",   32'(if0.err_cnt), 32'h2);
        check("err_level0", 32'(if0.level),   32'h0);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("err_cleared", 32'(if0.err_cnt), 32'h0);

        // Overflow: 5 pushes into a 4-deep FIFO
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        check("ovf0_head",  32'(if0.data),     32'h001);
        check("ovf0_level", 32'(if0.level),    32'h4);
        check("ovf0_flag",  32'(if0.overflow), 32'h1);
        check("ovf1_head",  32'(if1.data),     32'h002);
        check("ovf1_level", 32'(if1.level),    32'h4);
        check("ovf1_flag",  32'(if1.overflow), 32'h1);
        pop1();
        pop1();
        pop1();
        check("ovf0_after3", 32'(if0.data), 32'h004);
        check("ovf1_tail",   32'(if1.data), 32'h005);
        pop1();
        check("ovf0_empty", 32'(if0.level), 32'h0);
        check("ovf1_empty", 32'(if1.level), 32'h0);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("ovf_cleared", 32'(if0.overflow), 32'h0);

        // Partial frame abandoned by timeout, then a clean frame
        send_bits(make_frame(8'h2A, 1'b0, 1'b0), 5, -1);
        tick(TMO + 10);
        send_byte(8'h2A);
        check("tmo_data",  32'(if0.data),    32'h02A);
        check("tmo_level", 32'(if0.level),   32'h1);
        check("tmo_err",   32'(if0.err_cnt), 32'h0);
        pop1();

        // Short ps2_clk glitch mid-frame is filtered out
        send_bits(make_frame(8'h33, 1'b0, 1'b0), 11, 4);
        check("glitch_data",  32'(if0.data),    32'h033);
        check("glitch_level", 32'(if0.level),   32'h1);
        check("glitch_err",   32'(if0.err_cnt), 32'h0);

        // Reset mid-frame with an entry queued and a nonzero error count
        send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11, -1);
        check("pre_rst_err", 32'(if0.err_cnt), 32'h1);
        send_bits(make_frame(8'h4B, 1'b0, 1'b0), 6, -1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("midrst_ready", 32'(if0.ready),    32'h0);
        check("midrst_level", 32'(if0.level),    32'h0);
        check("midrst_err",   32'(if0.err_cnt),  32'h0);
        check("midrst_ovf",   32'(if1.overflow), 32'h0);
        send_byte(8'h5A);
        check("postrst_data",  32'(if0.data),  32'h05A);
        check("postrst_level", 32'(if0.level), 32'h1);
        check("postrst_err",   32'(if0.err_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx_fifo.md
Name: ps2_kbd_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver that deserialises 11-bit device-to-host frames into a key-event FIFO.
- Adds input glitch filtering and a frame timeout / resync.
- Decodes E0/F0 prefixes, so each FIFO entry is one complete key event: {ext, brk, code}.
- Selectable overflow policy, occupancy output, and a saturating frame-error counter.
- Sits between the board PS/2 pins and the keyboard consumer (keycode-to-ASCII lookup, CPU MMIO register).

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2.
FILTER_LEN, 4, consecutive equal synchronised ps2_clk samples needed to accept a level change; minimum 1.
TIMEOUT_CYC, 100000, clk cycles without a falling edge, mid-frame, before the partial frame is discarded.
OVF_MODE, 0, 0 = drop new event when full; 1 = overwrite oldest entry.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset; one clock; reset is asynchronous and active-high.
ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
ps2_data  in  1  raw PS/2 data pin (asynchronous).
nextdata_n  in  1  active-low pop request; honoured only while ready=1.
clr_flags  in  1  single-cycle pulse; clears overflow and err_cnt.
data  out  10  head entry {ext, brk, code[7:0]}; first-word-fall-through.
ready  out  1  FIFO non-empty.
level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
overflow  out  1  sticky; an event was lost (mode 0) or overwritten (mode 1).
err_cnt  out  8  frames rejected for start, stop or parity error; saturates at 255.

Behaviour:
Reset state (asynchronous): all pointers, level, bit count, timeout counter, prefix flags, overflow and err_cnt = 0; ready = 0; synchronisers and filter = 1 (idle bus).
- data is don't-care while ready = 0.

Input conditioning:
- ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Filtered ps2_clk changes only after FILTER_LEN consecutive identical synchronised samples.
- sample strobe = 1-cycle pulse on a 1-to-0 transition of filtered ps2_clk. Synchronised ps2_data is captured on that cycle.

Frame receiver (bit count 0..10):
- Frame bits: start 0, data D0..D7 (LSB first), odd parity, stop 1.
- On each strobe, store the bit and increment the count.
- On the strobe with count = 10: validate start = 0, stop = 1, and odd parity over D0..D7 plus the parity bit. Then count returns to 0.
- Invalid frame: err_cnt += 1 (saturating), ext and brk flags cleared, nothing pushed.
- Timeout: count != 0 and TIMEOUT_CYC cycles with no strobe → count = 0, frame discarded silently (err_cnt unchanged, flags kept).

Prefix decoder, for valid bytes only:
- 0xE0 sets ext; 0xF0 sets brk; neither is pushed.
- Any other byte pushes {ext, brk, byte}, then clears both flags.

FIFO:
- Push occurs on the clock edge of the validating strobe; ready and level update on the following cycle.
- Pop: at an edge where ready = 1 and nextdata_n = 0, the read pointer advances; data shows the next entry in the same cycle as the pointer update.
- Pop and push on the same edge: both happen, level unchanged. When full, the pop frees the slot, so there is no overflow.
- Full, push, no pop:
  - mode 0: event discarded, overflow = 1.
  - mode 1: oldest entry overwritten and both pointers advance, level stays FIFO_DEPTH, overflow = 1.
- Pointers wrap modulo FIFO_DEPTH.
- nextdata_n = 0 while ready = 0 has no effect.

Flags:
- clr_flags clears overflow and err_cnt.
- An overflow or error event in the same cycle as clr_flags takes precedence: overflow = 1, err_cnt = 1.

Reset mid-frame: partial frame, flags and FIFO contents are lost. No push is generated on reset release, even if a frame tail arrives later; that tail is rejected by the frame check or by the timeout.

Test Plan:
- Valid frame, code 0x1C, parity 0 → ready = 1 one cycle after the stop strobe, data = 0x01C, level = 1. Pulse nextdata_n low → ready = 0.
- Byte sequence E0, F0, 75 → exactly one entry, data = 0x375. A following 1C → 0x01C (flags cleared).
- Frame 0x1C with wrong parity, then one with stop = 0 → err_cnt = 2, level = 0. clr_flags → err_cnt = 0.
- FIFO_DEPTH = 4, push codes 01..05 without pops:
  - OVF_MODE 0 → head 0x001, level 4, overflow = 1.
  - OVF_MODE 1 → head 0x002, tail 0x005, overflow = 1.
- 5 bits of a frame, then TIMEOUT_CYC + 10 idle cycles, then a full valid 0x2A frame → data = 0x02A, err_cnt = 0.
- ps2_clk glitch low for FILTER_LEN - 1 cycles mid-frame → no strobe, frame still decodes correctly. Separately, assert rst after 6 bits → all outputs 0, and the following valid frame decodes.
